// File: rtl/fir_pipe_cfg.sv
// ---------------------------------------------------------------------------
// fir_pipe_cfg
// Pipelined N-tap signed FIR filter with serial run-time coefficient loading.
//
// A small IDLE/LOAD/RUN controller decides, each cycle, whether the input
// word is a coefficient (s_set_coeffs, which has priority) or a sample
// (s_axis_fir_tvalid). Samples pass through three register stages:
//   delay line (buffs) -> product registers -> output register
// so a sample accepted in cycle k appears on y_n in cycle k+3.
//
// Optional feature macro: FIR_SATURATE_EN
//   defined   : accumulator clamped to the Y_N_SIZE signed range, sat_flag set
//   undefined : y_n is the two's-complement wrap of the accumulator
//
// Ports
//   clk                in  single clock, rising edge
//   reset              in  asynchronous, active-low reset
//   x_n                in  sample (RUN) or coefficient in x_n[TAP_SIZE-1:0]
//   s_axis_fir_tvalid  in  sample valid
//   s_set_coeffs       in  coefficient-word valid (priority over samples)
//   y_n                out filter output, registered
//   m_axis_fir_tvalid  out y_n valid
//   coeffs_valid       out a full coefficient set is loaded
//   load_err           out one-cycle pulse on an aborted load
//   sat_flag           out current y_n was clamped
// ---------------------------------------------------------------------------
module fir_pipe_cfg #(
    parameter int TAP_SIZE    = 6,
    parameter int NBR_OF_TAPS = 8,
    parameter int X_N_SIZE    = 8,
    parameter int Y_N_SIZE    = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [X_N_SIZE-1:0] x_n,
    input  logic                s_axis_fir_tvalid,
    input  logic                s_set_coeffs,
    output logic [Y_N_SIZE-1:0] y_n,
    output logic                m_axis_fir_tvalid,
    output logic                coeffs_valid,
    output logic                load_err,
    output logic                sat_flag
);

    localparam int PW = TAP_SIZE + X_N_SIZE;           // full product width
    localparam int AW = PW + $clog2(NBR_OF_TAPS);      // overflow-free sum
    localparam int CW = $clog2(NBR_OF_TAPS + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t                      state;
    logic [CW-1:0]               load_cnt;
    logic signed [TAP_SIZE-1:0]  taps  [NBR_OF_TAPS];
    logic signed [X_N_SIZE-1:0]  buffs [NBR_OF_TAPS];
    logic signed [PW-1:0]        prods [NBR_OF_TAPS];
    logic                        s1_valid;
    logic                        s2_valid;

    logic signed [TAP_SIZE-1:0]  coeff_word;
    logic                        accept;
    logic                        clear_line;
    logic signed [AW-1:0]        acc;
    logic [Y_N_SIZE-1:0]         y_next;
    logic                        sat_next;

    assign coeff_word = x_n[TAP_SIZE-1:0];
    // A reload started from RUN flushes the history so the new set starts clean.
    assign clear_line = (state == RUN) && s_set_coeffs;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        accept = 1'b0;
        case (state)
            IDLE:    accept = !s_set_coeffs && s_axis_fir_tvalid && coeffs_valid;
            RUN:     accept = !s_set_coeffs && s_axis_fir_tvalid;
            default: accept = 1'b0;
        endcase
    end

    // Controller: state, load counter and the coefficient status flags.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            load_cnt     <= '0;
            coeffs_valid <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            load_err <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    if (s_set_coeffs) begin
                        load_cnt     <= CW'(1);
                        coeffs_valid <= 1'b0;
                        state        <= LOAD;
                    end else if (state == IDLE && accept) begin
                        state <= RUN;
                    end else if (state == RUN && !s_axis_fir_tvalid) begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    if (s_set_coeffs) begin
                        if (load_cnt == CW'(NBR_OF_TAPS - 1)) begin
                            coeffs_valid <= 1'b1;
                            load_cnt     <= '0;
                            state        <= IDLE;
                        end else begin
                            load_cnt <= load_cnt + CW'(1);
                        end
                    end else begin
                        // Gap inside a load: the partial set is unusable.
                        load_err <= 1'b1;
                        load_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 1: coefficient shift register and sample delay line. Every
    // coefficient word shifts in; a completed load overwrites all taps, and
    // a partial one leaves coeffs_valid low, so no state check is needed.
    // NOTE: these arrays are reset because a cleared history is observable on y_n.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NBR_OF_TAPS; i++) begin
                taps[i]  <= '0;
                buffs[i] <= '0;
            end
            s1_valid <= 1'b0;
        end else begin
            if (s_set_coeffs) begin
                taps[0] <= coeff_word;
                for (int i = 1; i < NBR_OF_TAPS; i++) taps[i] <= taps[i-1];
            end
            if (clear_line) begin
                for (int i = 0; i < NBR_OF_TAPS; i++) buffs[i] <= '0;
            end else if (accept) begin
                buffs[0] <= x_n;
                for (int i = 1; i < NBR_OF_TAPS; i++) buffs[i] <= buffs[i-1];
            end
            s1_valid <= accept;
        end
    end

    // Stage 2: full-precision products. Taps only change on an edge, so the
    // products of samples already in the delay line use the old set even
    // when a reload starts in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NBR_OF_TAPS; i++) prods[i] <= '0;
            s2_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NBR_OF_TAPS; i++) prods[i] <= PW'(taps[i]) * PW'(buffs[i]);
            s2_valid <= s1_valid;
        end
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < NBR_OF_TAPS; i++) acc = acc + AW'(prods[i]);
`ifdef FIR_SATURATE_EN
        y_next   = Y_N_SIZE'(acc);
        sat_next = 1'b0;
        if (Y_N_SIZE < AW) begin
            if (acc > AW'((1 << (Y_N_SIZE - 1)) - 1)) begin
                y_next   = {1'b0, {(Y_N_SIZE-1){1'b1}}};
                sat_next = 1'b1;
            end else if (acc < AW'(-(1 << (Y_N_SIZE - 1)))) begin
                y_next   = {1'b1, {(Y_N_SIZE-1){1'b0}}};
                sat_next = 1'b1;
            end
        end
`else
        y_next   = Y_N_SIZE'(acc);
        sat_next = 1'b0;
`endif
    end

    // Stage 3: output register, forced to zero whenever the result is invalid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_n               <= '0;
            m_axis_fir_tvalid <= 1'b0;
            sat_flag          <= 1'b0;
        end else begin
            y_n               <= s2_valid ? y_next : '0;
            m_axis_fir_tvalid <= s2_valid;
            sat_flag          <= s2_valid && sat_next;
        end
    end

endmodule

// File: tb/tb_fir_pipe_cfg.sv
// ---------------------------------------------------------------------------
// tb_fir_pipe_cfg
// Self-checking bench for fir_pipe_cfg. A behavioural model (word lists,
// a sample-history queue and integer convolution) predicts every output;
// a compare process checks the DUT against it on each falling edge, and
// directed phases add hand-computed literal expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fir_pipe_cfg;

    localparam int TS = 6;
    localparam int NT = 8;
    localparam int XS = 8;
    localparam int YS = 14;

    logic                 clk   = 1'b0;
    logic                 reset = 1'b1;
    logic [XS-1:0]        x_n   = '0;
    logic                 tv    = 1'b0;
    logic                 sc    = 1'b0;
    logic signed [YS-1:0] y_n;
    logic                 mv, cv, err, sat;

    always #5 clk = ~clk;

    fir_pipe_cfg #(
        .TAP_SIZE(TS), .NBR_OF_TAPS(NT), .X_N_SIZE(XS), .Y_N_SIZE(YS)
    ) dut (
        .clk(clk), .reset(reset), .x_n(x_n),
        .s_axis_fir_tvalid(tv), .s_set_coeffs(sc),
        .y_n(y_n), .m_axis_fir_tvalid(mv), .coeffs_valid(cv),
        .load_err(err), .sat_flag(sat)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic signed [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ model
    int  m_mode;              // 0 idle, 1 loading, 2 streaming
    int  m_words[$];          // coefficient words of the load in progress
    int  m_taps[NT];          // active set: m_taps[0] multiplies the newest sample
    int  m_hist[$];           // accepted samples, newest first
    bit  m_cv, m_err, m_v, m_sat;
    int  m_y;
    bit  pv[2], ps[2];
    int  py[2];
    bit  m_acc, m_ff;
    int  m_wd, m_xv, m_sum, m_fy;

    function automatic void fit(input int s, output int y, output bit f);
`ifdef FIR_SATURATE_EN
        int lim = 1 << (YS - 1);
        f = 1'b1;
        if (s > lim - 1)     y = lim - 1;
        else if (s < -lim)   y = -lim;
        else begin y = s; f = 1'b0; end
`else
        y = s & ((1 << YS) - 1);
        if (y >= (1 << (YS - 1))) y -= (1 << YS);
        f = 1'b0;
`endif
    endfunction

    task automatic clear_hist();
        m_hist.delete();
        repeat (NT) m_hist.push_back(0);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_words.delete(); clear_hist();
            foreach (m_taps[i]) m_taps[i] = 0;
            m_cv = 0; m_err = 0; m_v = 0; m_y = 0; m_sat = 0;
            pv = '{0, 0}; py = '{0, 0}; ps = '{0, 0};
        end else begin
            m_wd  = int'($signed(x_n[TS-1:0]));
            m_xv  = int'($signed(x_n));
            m_acc = 0;
            m_err = 0;
            m_v = pv[1]; m_y = py[1]; m_sat = ps[1];
            pv[1] = pv[0]; py[1] = py[0]; ps[1] = ps[0];
            case (m_mode)
                0: if (sc) begin
                       m_words = {m_wd}; m_cv = 0; m_mode = 1;
                   end else if (tv && m_cv) begin
                       m_acc = 1; m_mode = 2;
                   end
                1: if (sc) begin
                       m_words.push_back(m_wd);
                       if (m_words.size() == NT) begin
                           for (int i = 0; i < NT; i++) m_taps[i] = m_words[NT-1-i];
                           m_cv = 1; m_mode = 0;
                       end
                   end else begin
                       m_err = 1; m_mode = 0;
                   end
                default: if (sc) begin
                       m_words = {m_wd}; m_cv = 0; m_mode = 1; clear_hist();
                   end else if (tv) begin
                       m_acc = 1;
                   end else begin
                       m_mode = 0;
                   end
            endcase
            if (m_acc) begin
                m_hist.push_front(m_xv);
                void'(m_hist.pop_back());
                m_sum = 0;
                for (int i = 0; i < NT; i++) m_sum += m_taps[i] * m_hist[i];
                fit(m_sum, m_fy, m_ff);
                pv[0] = 1; py[0] = m_fy; ps[0] = m_ff;
            end else begin
                pv[0] = 0; py[0] = 0; ps[0] = 0;
            end
        end
    end

    // ------------------------------------------------------------ compare
    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_y_n",          $signed(y_n), m_y);
            check("cmp_m_valid",      mv,  int'(m_v));
            check("cmp_sat_flag",     sat, int'(m_sat));
            check("cmp_coeffs_valid", cv,  int'(m_cv));
            check("cmp_load_err",     err, int'(m_err));
        end
    end

    // ------------------------------------------------------------ drivers
    task automatic drive(input bit s, input bit v, input int x);
        @(negedge clk);
        sc  = s;
        tv  = v;
        x_n = XS'(x);
    endtask

    task automatic load_rand(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
    endtask

    int exp_y, exp_s;
    bit gap_pat[13] = '{1,1,1,1,0,0,1,1,1,1,0,0,0};

    initial begin
`ifdef FIR_SATURATE_EN
        exp_y = 8191;  exp_s = 1;
`else
        exp_y = -1272; exp_s = 0;
`endif
        // Reset state.
        #1 reset = 1'b0;
        #1;
        check("rst_y_n", $signed(y_n), 0);
        check("rst_m_valid", mv, 0);
        check("rst_coeffs_valid", cv, 0);
        check("rst_load_err", err, 0);
        check("rst_sat_flag", sat, 0);
        @(negedge clk);
        reset  = 1'b1;
        cmp_en = 1'b1;

        // Impulse response with coefficients 1..8.
        for (int i = 1; i <= NT; i++) drive(1'b1, 1'b0, i);
        drive(1'b0, 1'b0, 0);
        check("load_done_cv", cv, 1);
        for (int t = 0; t <= 12; t++) begin
            drive(1'b0, 1'b1, (t == 0) ? 1 : 0);
            if (t >= 3) begin
                check("impulse_y",     $signed(y_n), (t - 3 < NT) ? NT - (t - 3) : 0);
                check("impulse_model", m_y,          (t - 3 < NT) ? NT - (t - 3) : 0);
                check("impulse_valid", mv, 1);
            end
        end
        drive(1'b0, 1'b0, 0);

        // Saturation / wrap with 31 x 8 and x = 127 held.
        for (int i = 0; i < NT; i++) drive(1'b1, 1'b0, 31);
        for (int t = 0; t <= 12; t++) begin
            drive(1'b0, 1'b1, 127);
            if (t >= 11) begin
                check("sat_y",      $signed(y_n), exp_y);
                check("sat_flag",   sat, exp_s);
                check("sat_model",  m_y, exp_y);
            end
        end

        // Reload while streaming: three in-flight outputs still emerge.
        for (int i = 0; i < NT; i++) begin
            drive(1'b1, 1'b0, int'($urandom_range(0, 63)));
            if (i < 3)  check("reload_inflight", mv, 1);
            if (i == 3) check("reload_drained",  mv, 0);
        end
        repeat (NT) drive(1'b0, 1'b1, int'($urandom_range(0, 255)));
        repeat (4) drive(1'b0, 1'b0, 0);

        // Valid gap mid-stream: same gap on the output, 3 cycles later.
        for (int t = 0; t <= 12; t++) begin
            drive(1'b0, (t < 10) ? gap_pat[t] : 1'b0, int'($urandom_range(0, 255)));
            if (t >= 3) check("gap_valid", mv, int'(gap_pat[t-3]));
        end

        // Aborted load: pulse, coefficients invalid, samples ignored.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 5);
        drive(1'b0, 1'b1, 9);
        drive(1'b0, 1'b1, 9);
        check("abort_err_pulse", err, 1);
        check("abort_cv",        cv, 0);
        drive(1'b0, 1'b1, 9);
        check("abort_err_clear", err, 0);
        repeat (5) begin
            drive(1'b0, 1'b1, 9);
            check("abort_no_valid", mv, 0);
        end

        // Randomised traffic.
        repeat (60) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6)
                repeat ($urandom_range(1, 10))
                    drive(1'b0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 255)));
            else if (r < 9)
                load_rand(NT);
            else
                load_rand(int'($urandom_range(1, NT - 1)));
        end

        // Reset mid-stream.
        drive(1'b0, 1'b0, 0);
        load_rand(NT);
        repeat (5) drive(1'b0, 1'b1, int'($urandom_range(0, 255)));
        #2 reset = 1'b0;
        #1;
        check("midrst_y_n",   $signed(y_n), 0);
        check("midrst_valid", mv, 0);
        check("midrst_cv",    cv, 0);
        @(posedge clk);
        #1;
        check("midrst_hold_valid", mv, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) begin
            drive(1'b0, 1'b1, int'($urandom_range(0, 255)));
            check("postrst_no_valid", mv, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
